muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the single-cycle core.
- Sits between the register file read ports and its write port: it consumes rs1/rs2 operand data and produces one rd write-back.
- While an operation is in flight, the core stalls on o_busy.
- Radix-2 iterative datapath: one bit per clock, 32 iterations per operation.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- i_clk  in  1  clock, posedge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request; sampled only in IDLE
- i_funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1_data  in  32  operand A (dividend / multiplicand)
- i_rs2_data  in  32  operand B (divisor / multiplier)
- i_rd_addr  in  5  destination register, captured with the request
- o_busy  out  1  high from the accept edge until o_done deasserts; core stalls while high
- o_done  out  1  one-cycle result-valid pulse
- o_result  out  32  result; valid only while o_done=1, 0 otherwise
- o_rd_addr  out  5  captured i_rd_addr
- o_rd_wren  out  1  equals o_done; drives the regfile write enable (regfile ignores x0)

Behaviour:
- Reset: state=IDLE; o_busy, o_done, o_rd_wren, o_result, o_rd_addr all 0; internal accumulators cleared.
- A reset asserted mid-operation aborts the operation with no write-back. The unit is IDLE the cycle after the reset edge.
- State machine: IDLE -> (i_start) -> CALC -> (iteration counter==31) -> DONE -> IDLE. Fast path (optional feature only): IDLE -> DONE.
- IDLE: on an edge with i_start=1, capture funct3, rd_addr, and operand magnitudes/signs. Go to CALC, set o_busy=1, clear the 5-bit counter.
- i_start while not IDLE: ignored; the captured operands must not change.
- Signedness by op:
  - Signed: MULH, DIV, REM take both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Unsigned: MUL, MULHU, DIVU, REMU take both operands unsigned (MUL's low word is sign-agnostic).
- Signed operands are converted to magnitudes and the unsigned core runs on them. The final sign is applied in DONE:
  - Product sign = sA^sB.
  - Quotient sign = sA^sB.
  - Remainder sign = sA.
- Multiply: 64-bit shift-add over 32 iterations. MUL returns product[31:0]; the MULH variants return product[63:32] after signing.
- Divide: restoring, one quotient bit per cycle over 32 iterations. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: result computed by the normal iteration path.
  - DIV/DIVU -> 0xFFFFFFFF.
  - REM/REMU -> rs1.
- Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF):
  - DIV -> 0x80000000.
  - REM -> 0.
- Both special cases are fixed in DONE irrespective of datapath contents.
- Latency: with i_start sampled at edge 0, CALC occupies edges 1..32. o_done/o_rd_wren/o_result are valid between edges 33 and 34. o_busy falls at edge 34, where a new i_start may already be sampled (back-to-back throughput: 34 cycles).
- Simultaneous events: i_reset takes priority over i_start and over DONE; no write occurs.

Optional Feature:
- Macro MULDIV_FASTPATH_EN.
- Defined: in IDLE, divide-by-zero and signed-overflow requests skip CALC. With the request sampled at edge 0, o_done is valid between edges 1 and 2, and o_busy falls at edge 2. Results are identical to the full path.
- Undefined: every op takes the full 34-cycle path. No fast-path logic is synthesized.

Test Plan:
- Reset then idle -> all outputs 0; pulsing i_start with i_reset=1 gives no o_done.
- MUL rs1=7, rs2=0xFFFFFFFD -> o_result=0xFFFFFFEB, o_done exactly at cycle 33 after accept, o_rd_wren=1, o_rd_addr echoes the request.
- High products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Check latency 34 or 2 cycles per macro.
- Assert i_start with new operands mid-CALC -> ignored, original result returned. Reset at cycle 10 of CALC -> no o_done, next request completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2, one bit per clock, 32 iterations per op.
// Optional macro MULDIV_FASTPATH_EN lets divide-by-zero / signed-overflow requests skip CALC.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_wren
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_funct3;
  logic                r_sa;
  logic                r_sb;
  logic [XLEN-1:0]     r_mag_a;
  logic [XLEN-1:0]     r_mag_b;
  logic                r_dbz;
  logic                r_ovf;
  logic [2*XLEN-1:0]   r_acc;
  logic [4:0]          r_cnt;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_in_sa;
  logic                w_in_sb;
  logic [XLEN-1:0]     w_in_mag_a;
  logic [XLEN-1:0]     w_in_mag_b;
  logic                w_in_dbz;
  logic                w_in_ovf;
  logic                w_fast;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_trial;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_div_nxt;
  logic                w_neg;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_rs1;
  logic [XLEN-1:0]     w_result;

  // Operand signedness by opcode.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (i_funct3)
      3'b001, 3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b0;
      end
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
  end

  assign w_in_sa    = w_a_signed & i_rs1_data[XLEN-1];
  assign w_in_sb    = w_b_signed & i_rs2_data[XLEN-1];
  assign w_in_mag_a = w_in_sa ? (~i_rs1_data + 32'd1) : i_rs1_data;
  assign w_in_mag_b = w_in_sb ? (~i_rs2_data + 32'd1) : i_rs2_data;
  assign w_in_dbz   = i_funct3[2] & (i_rs2_data == 32'd0);
  assign w_in_ovf   = i_funct3[2] & ~i_funct3[0] &
                      (i_rs1_data == 32'h8000_0000) & (i_rs2_data == 32'hFFFF_FFFF);

`ifdef MULDIV_FASTPATH_EN
  assign w_fast = w_in_dbz | w_in_ovf;
`else
  assign w_fast = 1'b0;
`endif

  // Multiply step: acc = {high partial, multiplier}; add multiplicand on LSB, shift right.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}; quotient bits enter at LSB.
  assign w_trial   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_trial - {1'b0, r_mag_b};
  assign w_div_nxt = w_diff[XLEN] ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // Sign fix-up of the unsigned core results, with the special cases forced.
  assign w_neg  = r_sa ^ r_sb;
  assign w_prod = w_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_quot = w_neg ? (~r_acc[XLEN-1:0] + 32'd1) : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? (~r_acc[2*XLEN-1:XLEN] + 32'd1) : r_acc[2*XLEN-1:XLEN];
  assign w_rs1  = r_sa ? (~r_mag_a + 32'd1) : r_mag_a;

  always_comb begin
    w_result = 32'd0;
    case (r_funct3)
      3'b000:                 w_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_result = r_dbz ? 32'hFFFF_FFFF : (r_ovf ? 32'h8000_0000 : w_quot);
      3'b110, 3'b111:         w_result = r_dbz ? w_rs1 : (r_ovf ? 32'd0 : w_rem);
      default:                w_result = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_fast ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_funct3  <= 3'd0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_mag_a   <= 32'd0;
      r_mag_b   <= 32'd0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
      r_acc     <= 64'd0;
      r_cnt     <= 5'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rd_wren <= 1'b0;
      o_result  <= 32'd0;
      o_rd_addr <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done    <= 1'b0;
          o_rd_wren <= 1'b0;
          o_result  <= 32'd0;
          o_busy    <= i_start;
          if (i_start) begin
            r_funct3  <= i_funct3;
            r_sa      <= w_in_sa;
            r_sb      <= w_in_sb;
            r_mag_a   <= w_in_mag_a;
            r_mag_b   <= w_in_mag_b;
            r_dbz     <= w_in_dbz;
            r_ovf     <= w_in_ovf;
            r_acc     <= i_funct3[2] ? {32'd0, w_in_mag_a} : {32'd0, w_in_mag_b};
            r_cnt     <= 5'd0;
            o_rd_addr <= i_rd_addr;
          end
        end
        S_CALC: begin
          r_acc <= r_funct3[2] ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 5'd1;
        end
        S_DONE: begin
          o_done    <= 1'b1;
          o_rd_wren <= 1'b1;
          o_result  <= w_result;
        end
        default: begin
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
